// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) round-robin arbiter in front of a
// single-port memory. One transaction in flight at a time; a grant cycle in
// IDLE is followed by a WAIT state that ends on mem_rvalid or on timeout.
//
// Handshake: a requester holds x_req (and its command fields) until it sees
// x_gnt=1 in the same cycle. The memory sees mem_req=1 for exactly that grant
// cycle. Completion is a single-cycle x_rvalid pulse, driven either by mem_rvalid
// or by the wait-counter timeout. x_rdata is 0 whenever x_rvalid is 0.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;
  localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // Counter value this WAIT cycle would reach; 17 bits so TIMEOUT=65535 compares cleanly.
  logic [16:0] cnt_inc;
  logic        wait_done;
  logic [31:0] wait_rdata;

  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;

  // WAIT-state completion: real response wins over a coincident timeout.
  always_comb begin
    cnt_inc    = {1'b0, cnt_q} + 17'd1;
    wait_done  = mem_rvalid || (cnt_inc == TIMEOUT_CNT);
    wait_rdata = mem_rvalid ? mem_rdata : 32'd0;
  end

  // Next-state, arbitration and output decode; reset cycle blanks all handshake outputs.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    i_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = 32'd0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;

    case (state_q)
      IDLE: begin
        // Fetch wins when alone, or when both request and data went last.
        if (i_req && (!d_req || last_q == OWNER_D)) begin
          i_gnt    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = i_addr;
          last_d   = OWNER_I;
          cnt_d    = 16'd0;
          state_d  = I_WAIT;
        end else if (d_req) begin
          d_gnt     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          last_d    = OWNER_D;
          cnt_d     = 16'd0;
          state_d   = D_WAIT;
        end
      end
      I_WAIT: begin
        cnt_d = cnt_inc[15:0];
        if (wait_done) begin
          i_rvalid = 1'b1;
          i_rdata  = wait_rdata;
          cnt_d    = 16'd0;
          err_d    = err_q | ~mem_rvalid;
          state_d  = IDLE;
        end
      end
      D_WAIT: begin
        cnt_d = cnt_inc[15:0];
        if (wait_done) begin
          d_rvalid = 1'b1;
          d_rdata  = wait_rdata;
          cnt_d    = 16'd0;
          err_d    = err_q | ~mem_rvalid;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!reset) begin
      i_gnt     = 1'b0;
      i_rvalid  = 1'b0;
      i_rdata   = 32'd0;
      d_gnt     = 1'b0;
      d_rvalid  = 1'b0;
      d_rdata   = 32'd0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
    end
  end

  // State, ownership, wait counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= OWNER_D;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max WAIT cycles before a transaction is force-completed (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low (reset==0 at a rising clk edge resets the block).
REQ-004 SHALL have port i_req  input  1  fetch-port request; held with i_addr stable until i_gnt.
REQ-005 SHALL have port i_addr  input  32  fetch byte address.
REQ-006 SHALL have port i_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port i_rvalid  output  1  fetch completion; i_rdata valid.
REQ-008 SHALL have port i_rdata  output  32  fetched instruction word.
REQ-009 SHALL have port d_req  input  1  data-port request; held with d_we, d_addr and d_wdata stable until d_gnt.
REQ-010 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have ports d_addr  input  32 and d_wdata  input  32  data address and store data.
REQ-012 SHALL have ports d_gnt  output  1, d_rvalid  output  1 and d_rdata  output  32, same meaning as the fetch-port equivalents.
REQ-013 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32 and mem_wdata  output  32  single-port memory command.
REQ-014 SHALL have ports mem_rvalid  input  1 and mem_rdata  input  32  memory completion and read data.
REQ-015 SHALL have ports busy  output  1 (state != IDLE) and err  output  1 (sticky timeout flag).

Function
REQ-016 SHALL implement FSM states IDLE, I_WAIT and D_WAIT, plus a 1-bit last_owner register (I/D) and a 16-bit wait counter.
REQ-017 In IDLE with exactly one request, SHALL grant that requester.
REQ-018 In IDLE with both i_req and d_req, SHALL grant the port opposite to last_owner (round-robin).
REQ-019 In a grant cycle, SHALL combinationally assert x_gnt=1 and mem_req=1, drive mem_addr, mem_we and mem_wdata from the winner, set last_owner to the winner, and move to x_WAIT at the next edge.
REQ-020 SHALL force mem_we=0 for fetch grants and mem_wdata=0 for fetch grants.
REQ-021 Outside grant cycles, SHALL drive mem_req, mem_we, mem_addr and mem_wdata to 0.
REQ-022 In x_WAIT, SHALL increment the wait counter each cycle.
REQ-023 On mem_rvalid=1 in x_WAIT, SHALL assert x_rvalid=1 for exactly that cycle with x_rdata=mem_rdata (combinational pass-through), clear the counter, and return to IDLE.
REQ-024 SHALL issue the rvalid completion for stores as well; d_rdata on a store completion is don't-care.
REQ-025 SHALL ignore mem_rvalid in IDLE and in grant cycles.
REQ-026 SHALL give a minimum memory latency of 1 cycle, a minimum transaction length of 2 cycles, and a throughput of L+1 cycles per transaction for memory latency L.
REQ-027 If the counter reaches TIMEOUT in x_WAIT with mem_rvalid=0, SHALL complete that cycle with x_rvalid=1 and x_rdata=0, set err=1, and return to IDLE.
REQ-028 SHALL hold err at 1 until reset.
REQ-029 SHALL treat a late mem_rvalid arriving after a timeout as ignored, per REQ-025.
REQ-030 SHALL drive x_rdata=0 whenever x_rvalid=0.
REQ-031 SHALL never assert x_gnt and x_rvalid on the same port in the same cycle, and SHALL never grant both ports in the same cycle.
REQ-032 SHALL leave requester behaviour undefined if i_req or d_req drops before its grant; the arbiter re-evaluates every IDLE cycle.

Reset
REQ-033 While reset==0 at a clock edge, SHALL set state=IDLE, last_owner=D, counter=0 and err=0.
REQ-034 During the reset cycle, SHALL force every gnt, rvalid, rdata and mem_* output to 0 regardless of inputs.
REQ-035 On reset asserted mid-transaction, SHALL abandon the transaction with no rvalid and ignore any subsequent mem_rvalid in IDLE.

Verification
REQ-036 Bench SHALL cover: i_req only, addr 0x100, mem_rvalid 3 cycles after grant with rdata 0x00000013 -> i_gnt in cycle 0, i_rvalid in cycle 3 with rdata 0x00000013, busy high in cycles 1-3.
REQ-037 Bench SHALL cover: i_req and d_req both held from reset release -> grants alternate I, D, I, D; no simultaneous grants.
REQ-038 Bench SHALL cover: store with d_we=1, addr 0x2000, wdata 0xCAFEF00D -> mem_we=1, mem_addr=0x2000, mem_wdata=0xCAFEF00D in the grant cycle only; d_rvalid pulses on mem_rvalid.
REQ-039 Bench SHALL cover: TIMEOUT=4 with mem_rvalid never asserted -> x_rvalid with rdata=0 on the 4th WAIT cycle, err=1 and held, next request granted normally.
REQ-040 Bench SHALL cover: reset=0 asserted in D_WAIT, then mem_rvalid=1 after reset release -> no d_rvalid, state IDLE, err=0.
REQ-041 Bench SHALL cover: mem_rvalid pulsed while IDLE with no requests -> no rvalid output and no state change.
